// File: rtl/matrix_mult_pkg.sv
// rtl/matrix_mult_pkg.sv - shared types, defaults and width helper for the matrix-multiply block
package matrix_mult_pkg;

  localparam int N_DEFAULT = 3;
  localparam int M_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mm_state_e;

  // Index width never collapses to zero bits, even for degenerate sizes.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mm_wb_delay.sv
// rtl/mm_wb_delay.sv - LAT-stage shift register aligning write-back strobe and address with MAC latency
module mm_wb_delay #(
  parameter int LAT = 1,
  parameter int IW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_en,
  input  logic [IW-1:0] in_row,
  input  logic [IW-1:0] in_col,
  output logic          out_en,
  output logic [IW-1:0] out_row,
  output logic [IW-1:0] out_col
);

  localparam int W = 1 + 2 * IW;

  logic [W-1:0] pipe_q [LAT];
  logic [W-1:0] pipe_d [LAT];

  always_comb begin
    for (int s = 0; s < LAT; s++) pipe_d[s] = '0;
    if (!flush) begin
      pipe_d[0] = {in_en, in_row, in_col};
      for (int s = 1; s < LAT; s++) pipe_d[s] = pipe_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) pipe_q[s] <= '0;
    end else begin
      for (int s = 0; s < LAT; s++) pipe_q[s] <= pipe_d[s];
    end
  end

  assign {out_en, out_row, out_col} = pipe_q[LAT-1];

endmodule

// File: rtl/matrix_mult_seq_ctrl.sv
// rtl/matrix_mult_seq_ctrl.sv - (i,j,k) loop-nest sequencer driving one MAC per cycle with delayed write-back
module matrix_mult_seq_ctrl
  import matrix_mult_pkg::*;
#(
  parameter int  N       = N_DEFAULT,
  parameter int  MAC_LAT = 1,
  localparam int IW      = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          advance,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] row_idx,
  output logic [IW-1:0] col_idx,
  output logic [IW-1:0] k_idx,
  output logic          acc_clr,
  output logic          mac_en,
  output logic          wr_en,
  output logic [IW-1:0] wr_row,
  output logic [IW-1:0] wr_col
);

  localparam int            DW         = clog2_min1(MAC_LAT);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);

  mm_state_e     state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DW-1:0] drain_q, drain_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    drain_d = drain_q;
    busy    = 1'b0;
    done    = 1'b0;
    mac_en  = 1'b0;
    acc_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        mac_en  = advance;
        acc_clr = advance && (k_q == '0);
        // Odometer carry k -> j -> i; the final carry out of i ends the nest.
        if (advance) begin
          if (k_q != IDX_LAST) begin
            k_d = k_q + IW'(1);
          end else begin
            k_d = '0;
            if (j_q != IDX_LAST) begin
              j_d = j_q + IW'(1);
            end else begin
              j_d = '0;
              if (i_q != IDX_LAST) begin
                i_d = i_q + IW'(1);
              end else begin
                i_d     = '0;
                drain_d = '0;
                state_d = ST_DRAIN;
              end
            end
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      drain_d = '0;
    end
  end

  assign row_idx = i_q;
  assign col_idx = j_q;
  assign k_idx   = k_q;

  mm_wb_delay #(
    .LAT (MAC_LAT),
    .IW  (IW)
  ) u_wb_delay (
    .clk     (clk),
    .rst_n   (rst),
    .flush   (abort),
    .in_en   (mac_en && (k_q == IDX_LAST)),
    .in_row  (i_q),
    .in_col  (j_q),
    .out_en  (wr_en),
    .out_row (wr_row),
    .out_col (wr_col)
  );

endmodule

// File: tb/tb_matrix_mult_seq_ctrl.sv
// tb/tb_matrix_mult_seq_ctrl.sv - directed self-checking bench for matrix_mult_seq_ctrl
module tb_matrix_mult_seq_ctrl;
  import matrix_mult_pkg::*;

  localparam int N3 = 3;
  localparam int N4 = 4;
  localparam int IW = 2;
  localparam int M  = M_DEFAULT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start3 = 0, abort3 = 0, adv3 = 1;
  logic          busy3, done3, acc_clr3, mac_en3, wr_en3;
  logic [IW-1:0] row3, col3, k3, wr_row3, wr_col3;

  logic          start4 = 0, abort4 = 0, adv4 = 1;
  logic          busy4, done4, acc_clr4, mac_en4, wr_en4;
  logic [IW-1:0] row4, col4, k4, wr_row4, wr_col4;

  matrix_mult_seq_ctrl #(.N(N3), .MAC_LAT(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .advance(adv3),
    .busy(busy3), .done(done3), .row_idx(row3), .col_idx(col3), .k_idx(k3),
    .acc_clr(acc_clr3), .mac_en(mac_en3), .wr_en(wr_en3),
    .wr_row(wr_row3), .wr_col(wr_col3)
  );

  matrix_mult_seq_ctrl #(.N(N4), .MAC_LAT(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .advance(adv4),
    .busy(busy4), .done(done4), .row_idx(row4), .col_idx(col4), .k_idx(k4),
    .acc_clr(acc_clr4), .mac_en(mac_en4), .wr_en(wr_en4),
    .wr_row(wr_row4), .wr_col(wr_col4)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int mac_cnt, mac_first, mac_last, clr_cnt, clr_bad, wr_cnt, wr_first, wr_last;
  int done_cnt, done_cyc, idx_bad, wr_bad;
  logic busy_ab, wr_ab;

  // Cycle c is the interval after edge c; cycle 0 is the cycle that presents start.
  task automatic begin_cycle0();
    @(posedge clk); #1;
  endtask

  task automatic mon3(input int ncyc, input int st_a, input int st_b, input int st_c,
                      input int ab_cyc, input int rs_cyc, input bit hold_start);
    int m, w;
    m = 0; w = 0;
    mac_cnt = 0; mac_first = -1; mac_last = -1; clr_cnt = 0; clr_bad = 0;
    wr_cnt = 0; wr_first = -1; wr_last = -1; done_cnt = 0; done_cyc = -1;
    idx_bad = 0; wr_bad = 0; busy_ab = 1'bx; wr_ab = 1'bx;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      adv3   = !(c == st_a || c == st_b || c == st_c);
      abort3 = (c == ab_cyc);
      start3 = hold_start || (c == rs_cyc);
      if (c == rs_cyc) begin
        m = 0; w = 0; mac_cnt = 0; mac_first = -1; clr_cnt = 0;
        wr_cnt = 0; wr_first = -1; done_cnt = 0; done_cyc = -1;
      end
      #1;
      if (c == ab_cyc + 1) begin busy_ab = busy3; wr_ab = wr_en3; end
      if (mac_en3 || (busy3 && !adv3 && m < N3*N3*N3)) begin
        if (int'(row3) != m / (N3*N3) || int'(col3) != (m / N3) % N3 || int'(k3) != m % N3)
          idx_bad++;
      end
      if (acc_clr3 && !mac_en3) clr_bad++;
      if (mac_en3) begin
        mac_cnt++;
        if (mac_first < 0) mac_first = c;
        mac_last = c;
        if ((m % N3 == 0) != acc_clr3) clr_bad++;
        if (acc_clr3) clr_cnt++;
        m++;
      end
      if (wr_en3) begin
        wr_cnt++;
        if (wr_first < 0) wr_first = c;
        wr_last = c;
        if (int'(wr_row3) != w / N3 || int'(wr_col3) != w % N3) wr_bad++;
        w++;
      end
      if (done3) begin done_cnt++; done_cyc = c; end
    end
  endtask

  logic [M-1:0] xm [N4][N4];
  logic [M-1:0] ym [N4][N4];
  logic [M-1:0] om [N4][N4];
  logic [M-1:0] ref_o;
  logic [M-1:0] acc;
  logic [M-1:0] accq [$];
  int act;

  initial begin
    // Reset state
    #12;
    check("rst_busy", busy3, 0);
    check("rst_outs", {done3, acc_clr3, mac_en3, wr_en3, row3, col3, k3, wr_row3, wr_col3}, 0);
    rst = 1'b1;

    // 1: plain run, advance held high
    begin_cycle0(); start3 = 1;
    mon3(32, -1, -1, -1, -1, -1, 0);
    check("t1_mac_cnt", mac_cnt, 27);
    check("t1_mac_first", mac_first, 1);
    check("t1_mac_last", mac_last, 27);
    check("t1_clr_cnt", clr_cnt, 9);
    check("t1_clr_bad", clr_bad, 0);
    check("t1_idx_bad", idx_bad, 0);
    check("t1_wr_cnt", wr_cnt, 9);
    check("t1_wr_first", wr_first, 4);
    check("t1_wr_last", wr_last, 28);
    check("t1_wr_order", wr_bad, 0);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_cyc", done_cyc, 29);

    // 2: stalls on cycles 5, 6 and 27
    begin_cycle0(); start3 = 1;
    mon3(36, 5, 6, 27, -1, -1, 0);
    check("t2_mac_cnt", mac_cnt, 27);
    check("t2_mac_last", mac_last, 30);
    check("t2_idx_hold", idx_bad, 0);
    check("t2_wr_cnt", wr_cnt, 9);
    check("t2_wr_order", wr_bad, 0);
    check("t2_done_cyc", done_cyc, 32);
    check("t2_done_cnt", done_cnt, 1);

    // 3: abort at cycle 10, restart at cycle 12
    begin_cycle0(); start3 = 1;
    mon3(45, -1, -1, -1, 10, 12, 0);
    check("t3_busy_after_abort", busy_ab, 0);
    check("t3_wr_after_abort", wr_ab, 0);
    check("t3_mac_first", mac_first, 13);
    check("t3_mac_cnt", mac_cnt, 27);
    check("t3_idx_bad", idx_bad, 0);
    check("t3_wr_cnt", wr_cnt, 9);
    check("t3_wr_order", wr_bad, 0);
    check("t3_done_cyc", done_cyc, 41);
    check("t3_done_cnt", done_cnt, 1);

    // 4: start held high throughout
    begin_cycle0(); start3 = 1;
    mon3(30, -1, -1, -1, -1, -1, 1);
    check("t4_mac_cnt", mac_cnt, 27);
    check("t4_done_cyc", done_cyc, 29);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_idle_after_done", busy3, 0);
    @(posedge clk); #2;
    check("t4_restart_busy", busy3, 1);
    check("t4_restart_mac", {mac_en3, acc_clr3, row3, col3, k3}, 32'b11_00_00_00);
    start3 = 0; abort3 = 1;
    @(posedge clk); #1; abort3 = 0;

    // 5: asynchronous reset pulse at cycle 15
    begin_cycle0(); start3 = 1;
    mon3(15, -1, -1, -1, -1, -1, 0);
    check("t5_busy_before", busy3, 1);
    rst = 1'b0;
    #1;
    check("t5_busy_in_rst", busy3, 0);
    check("t5_outs_in_rst", {done3, acc_clr3, mac_en3, wr_en3, row3, col3, k3, wr_row3, wr_col3}, 0);
    rst = 1'b1;
    act = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #2;
      if (busy3 || done3 || wr_en3 || mac_en3) act++;
    end
    check("t5_idle_after_rst", act, 0);

    // 6: N=4, MAC_LAT=3 with a datapath model
    for (int r = 0; r < N4; r++)
      for (int c = 0; c < N4; c++) begin
        xm[r][c] = M'((r * 4 + c) * 37 + 11);
        ym[r][c] = M'((r * 7 + c * 13) * 19 + 250);
      end
    acc = '0;
    accq.delete();
    begin_cycle0(); start4 = 1;
    mac_cnt = 0; wr_cnt = 0; wr_first = -1; wr_last = -1; wr_bad = 0;
    done_cnt = 0; done_cyc = -1; idx_bad = 0;
    for (int c = 1; c <= 72; c++) begin
      @(posedge clk); #1; start4 = 0; #1;
      if (mac_en4) begin
        if (int'(row4) != mac_cnt / 16 || int'(col4) != (mac_cnt / 4) % 4 || int'(k4) != mac_cnt % 4)
          idx_bad++;
        acc = (acc_clr4 ? M'(0) : acc) + M'(xm[row4][k4] * ym[k4][col4]);
        if (k4 == 2'd3) accq.push_back(acc);
        mac_cnt++;
      end
      if (wr_en4) begin
        if (int'(wr_row4) != wr_cnt / 4 || int'(wr_col4) != wr_cnt % 4) wr_bad++;
        if (wr_first < 0) wr_first = c;
        wr_last = c;
        if (accq.size() > 0) om[wr_row4][wr_col4] = accq.pop_front();
        else wr_bad++;
        wr_cnt++;
      end
      if (done4) begin done_cnt++; done_cyc = c; end
    end
    check("t6_mac_cnt", mac_cnt, 64);
    check("t6_idx_bad", idx_bad, 0);
    check("t6_wr_cnt", wr_cnt, 16);
    check("t6_wr_first", wr_first, 7);
    check("t6_wr_last", wr_last, 67);
    check("t6_wr_order", wr_bad, 0);
    check("t6_done_cyc", done_cyc, 68);
    check("t6_done_cnt", done_cnt, 1);
    for (int r = 0; r < N4; r++)
      for (int c = 0; c < N4; c++) begin
        ref_o = '0;
        for (int k = 0; k < N4; k++) ref_o = ref_o + M'(xm[r][k] * ym[k][c]);
        check($sformatf("t6_o_%0d_%0d", r, c), om[r][c], ref_o);
      end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
